// File: rtl/rtc_dir_sequencer.sv
// rtl/rtc_dir_sequencer.sv - sweeps RTC register indices 0..LAST_INDEX through a bus controller with timeout
module rtc_dir_sequencer #(
    parameter int LAST_INDEX = 9,
    parameter int TIMEOUT    = 255
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       bus_done,
    input  logic [7:0] bus_data_in,
    output logic [3:0] dir_index,
    output logic       dir_en,
    output logic       bus_req,
    output logic [7:0] data_out,
    output logic [3:0] data_index,
    output logic       data_valid,
    output logic       busy,
    output logic       done,
    output logic       error
);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        REQ,
        CAPTURE,
        FINISH
    } state_t;

    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);
    localparam logic [3:0] LAST_IDX     = 4'(LAST_INDEX);

    state_t     state;
    state_t     state_next;
    logic [7:0] timeout_cnt;
    logic       timeout_hit;
    logic       last_hit;

    assign timeout_hit = (timeout_cnt == TIMEOUT_LAST);
    assign last_hit    = (dir_index == LAST_IDX);

    // bus_done is checked before the timeout so a completion on the final allowed cycle still counts
    always_comb begin
        state_next = state;
        dir_en     = 1'b0;
        bus_req    = 1'b0;
        data_valid = 1'b0;
        done       = 1'b0;
        busy       = 1'b1;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (start) begin
                    state_next = SETUP;
                end
            end
            SETUP: begin
                dir_en     = 1'b1;
                state_next = REQ;
            end
            REQ: begin
                dir_en  = 1'b1;
                bus_req = 1'b1;
                if (bus_done) begin
                    state_next = CAPTURE;
                end else if (timeout_hit) begin
                    state_next = FINISH;
                end
            end
            CAPTURE: begin
                data_valid = 1'b1;
                state_next = last_hit ? FINISH : SETUP;
            end
            FINISH: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: begin
                busy       = 1'b0;
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            dir_index   <= 4'd0;
            data_out    <= 8'h00;
            data_index  <= 4'd0;
            error       <= 1'b0;
            timeout_cnt <= 8'd0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (start) begin
                        dir_index <= 4'd0;
                        error     <= 1'b0;
                    end
                end
                SETUP: begin
                    timeout_cnt <= 8'd0;
                end
                REQ: begin
                    if (bus_done) begin
                        data_out   <= bus_data_in;
                        data_index <= dir_index;
                    end else if (timeout_hit) begin
                        error <= 1'b1;
                    end else begin
                        timeout_cnt <= timeout_cnt + 8'd1;
                    end
                end
                CAPTURE: begin
                    if (!last_hit) begin
                        dir_index <= dir_index + 4'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: doc/rtc_dir_sequencer.md
RTC_DIR_SEQUENCER -- requirements
Module: rtc_dir_sequencer

Interface
REQ-001 Parameter LAST_INDEX, default 9, SHALL be the final address index of a sweep; the sweep SHALL start at index 0.
REQ-002 Parameter TIMEOUT, default 255, SHALL be the maximum number of REQ cycles allowed to wait for bus_done (8-bit counter).
REQ-003 clk  input  1  SHALL be the single clock; all state changes on rising edge.
REQ-004 reset  input  1  SHALL be a synchronous, active-high reset.
REQ-005 start  input  1  SHALL be a sweep request, sampled in IDLE only.
REQ-006 bus_done  input  1  SHALL be the bus-controller completion strobe, honoured in REQ only.
REQ-007 bus_data_in  input  8  SHALL be the RTC register byte, valid while bus_done=1.
REQ-008 dir_index  output  4  SHALL be the current address index, driven to the address decoder's binary input.
REQ-009 dir_en  output  1  SHALL be the address decoder enable.
REQ-010 bus_req  output  1  SHALL be the bus transaction request.
REQ-011 data_out  output  8  SHALL be the last captured byte.
REQ-012 data_index  output  4  SHALL be the index that data_out belongs to.
REQ-013 data_valid  output  1  SHALL be a one-cycle pulse marking new data_out/data_index.
REQ-014 busy  output  1  SHALL be high in every state except IDLE.
REQ-015 done  output  1  SHALL be a one-cycle pulse at sweep end.
REQ-016 error  output  1  SHALL be a sticky timeout flag.

Function
REQ-017 The block SHALL be an FSM with states IDLE, SETUP, REQ, CAPTURE, FINISH; all outputs SHALL be registered or decoded from state only.
REQ-018 IDLE: start=1 -> SETUP with dir_index=0, error cleared; start=0 -> stay.
REQ-019 SETUP (exactly 1 cycle): dir_en=1, bus_req=0, timeout counter cleared; -> REQ.
REQ-020 REQ: dir_en=1, bus_req=1, dir_index stable; bus_done=1 -> CAPTURE, with data_out<=bus_data_in and data_index<=dir_index on that edge.
REQ-021 REQ: bus_done=0 -> counter increments; when counter reaches TIMEOUT-1 with bus_done=0, -> FINISH, error<=1, no data_valid for that index.
REQ-022 bus_done=1 on the same cycle the timeout is reached SHALL be treated as success (bus_done wins).
REQ-023 CAPTURE (exactly 1 cycle): data_valid=1, dir_en=0, bus_req=0; dir_index==LAST_INDEX -> FINISH, else dir_index<=dir_index+1 and -> SETUP.
REQ-024 FINISH (exactly 1 cycle): done=1, dir_en=0, bus_req=0; -> IDLE.
REQ-025 dir_index SHALL never exceed LAST_INDEX; no wrap past LAST_INDEX.
REQ-026 start while busy=1 SHALL be ignored; no queuing.
REQ-027 bus_done outside REQ SHALL be ignored with no state or data change.
REQ-028 Minimum per-index latency SHALL be 3 cycles (SETUP, REQ, CAPTURE) when bus_done arrives on the first REQ cycle; a full default sweep SHALL then take 30 cycles from SETUP of index 0 to done.
REQ-029 dir_en SHALL be low in IDLE, CAPTURE and FINISH, so the decoder outputs 8'h00 between transactions.
REQ-030 error SHALL remain set through IDLE until the next accepted start.

Reset
REQ-031 reset=1 SHALL force IDLE on the next edge from any state, including mid-transaction in REQ.
REQ-032 Reset values: dir_index=0, dir_en=0, bus_req=0, data_out=8'h00, data_index=0, data_valid=0, busy=0, done=0, error=0, timeout counter=0.
REQ-033 reset SHALL take priority over start and bus_done on the same edge.

Verification
REQ-034 start pulse, bus_done returned on first REQ cycle with bus_data_in=8'h10+index -> ten data_valid pulses with data_index 0..9, data_out 8'h10..8'h19, done 30 cycles after first SETUP, error=0.
REQ-035 bus_done held 0 at index 3 -> 254 REQ-cycle wait then FINISH, done=1, error=1, data_valid seen for indices 0..2 only, dir_en=0 afterwards.
REQ-036 bus_done=1 exactly on cycle counter=TIMEOUT-1 -> CAPTURE, data_valid=1, error stays 0, sweep continues.
REQ-037 start re-pulsed during REQ of index 5 and bus_done pulsed during SETUP -> no restart, no extra data_valid, sweep completes normally.
REQ-038 reset asserted during REQ of index 4 -> next cycle all outputs at reset values; subsequent start restarts at index 0.
REQ-039 Sweep ending with error, then new start -> error cleared on entry to SETUP, clean sweep completes with error=0.
